// File: rtl/idecode.sv
// RV32I decode stage: main/ALU decode, immediate extend, 32x32 register file
// with write-through bypass, and the flushable ID/EX pipeline register.
module idecode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE
);

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       reg_write, alu_src, mem_write, branch, jump;
  logic [1:0] imm_src, result_src, alu_op;
  logic [2:0] alu_control;
  logic [XLEN-1:0] imm_ext, rd1, rd2;
  logic [XLEN-1:0] rf [32];
  idex_t d, e;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    case (opcode)
      7'b0000011: begin reg_write = 1'b1; alu_src = 1'b1; result_src = 2'b01; end
      7'b0100011: begin imm_src = 2'b01; alu_src = 1'b1; mem_write = 1'b1; end
      7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
      7'b1100011: begin imm_src = 2'b10; branch = 1'b1; alu_op = 2'b01; end
      7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; alu_op = 2'b10; end
      7'b1101111: begin reg_write = 1'b1; imm_src = 2'b11; result_src = 2'b10; jump = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10:
        case (funct3)
          3'b000:  alu_control = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (imm_src)
      2'b01:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  // x0 is never written, so its entry stays at its reset value of 0
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWriteW && RdW != 5'd0) begin
      rf[RdW] <= ResultW;
    end
  end

  // Write-through bypass lets a same-cycle writeback reach execute
  assign rd1 = (Rs1D == 5'd0) ? '0 : (RegWriteW && RdW == Rs1D) ? ResultW : rf[Rs1D];
  assign rd2 = (Rs2D == 5'd0) ? '0 : (RegWriteW && RdW == Rs2D) ? ResultW : rf[Rs2D];

  always_comb begin
    d             = '0;
    d.reg_write   = reg_write;
    d.result_src  = result_src;
    d.mem_write   = mem_write;
    d.jump        = jump;
    d.branch      = branch;
    d.alu_control = alu_control;
    d.alu_src     = alu_src;
    d.rd1         = rd1;
    d.rd2         = rd2;
    d.imm         = imm_ext;
    d.pc          = PCD;
    d.pc4         = PCPlus4D;
    d.rs1         = Rs1D;
    d.rs2         = Rs2D;
    d.rd          = InstrD[11:7];
  end

  always_ff @(posedge clk) begin
    if (!reset || FlushE) e <= '0;
    else                  e <= d;
  end

  assign RD1E        = e.rd1;
  assign RD2E        = e.rd2;
  assign ImmExtE     = e.imm;
  assign PCE         = e.pc;
  assign PCPlus4E    = e.pc4;
  assign Rs1E        = e.rs1;
  assign Rs2E        = e.rs2;
  assign RdE         = e.rd;
  assign RegWriteE   = e.reg_write;
  assign MemWriteE   = e.mem_write;
  assign JumpE       = e.jump;
  assign BranchE     = e.branch;
  assign ALUSrcE     = e.alu_src;
  assign ResultSrcE  = e.result_src;
  assign ALUControlE = e.alu_control;

endmodule

// File: doc/idecode.md
# idecode

Decode stage of the 5-stage RV32I pipeline. Takes the fetched instruction and PC values from the IF/ID register and produces the control word, register operands and sign-extended immediate for execute. Holds the 32x32 register file, which the writeback stage writes. Ends in the ID/EX pipeline register, which supports flushing for branch/jump bubbles.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  load bubble into ID/EX
- Rs1D, Rs2D  out  5 each  combinational InstrD[19:15], InstrD[24:20], for the hazard unit
- RD1E, RD2E  out  32 each  registered source operands
- ImmExtE  out  32  registered immediate
- PCE, PCPlus4E  out  32 each  registered PC values
- Rs1E, Rs2E, RdE  out  5 each  registered register indices
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

## Operation
- **Main decode on opcode.** Each opcode sets RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump:
  - 0000011 lw: 1/00/1/0/01/0/00/0
  - 0100011 sw: 0/01/1/1/xx→00/0/00/0
  - 0110011 R: 1/xx→00/0/0/00/0/10/0
  - 1100011 beq: 0/10/0/0/00/1/01/0
  - 0010011 I-ALU: 1/00/1/0/00/0/10/0
  - 1101111 jal: 1/11/0/0/10/0/00/1
  - Any other opcode: all control 0 (treated as a nop).
- **ALU decode.**
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10, by funct3: 000 → sub if op[5]&funct7[5], else add; 010 → slt; 110 → or; 111 → and; others → add.
- **Immediate extend, by ImmSrc.**
  - 00 I: {{20{i[31]}}, i[31:20]}
  - 01 S: {{20{i[31]}}, i[31:25], i[11:7]}
  - 10 B: {{20{i[31]}}, i[7], i[30:25], i[11:8], 0}
  - 11 J: {{12{i[31]}}, i[19:12], i[20], i[30:21], 0}
- **Register file.**
  - 32 entries; writes on the rising clk edge when RegWriteW=1 and RdW≠0.
  - x0 always reads 0 and writes to it are dropped.
  - Reads are combinational with write-through bypass: if RegWriteW=1, RdW≠0 and RdW equals the read index, the read returns ResultW.
- **ID/EX register.** Captures all decode outputs, PCD, PCPlus4D, Rs1/Rs2/Rd (InstrD[11:7]) every cycle.

## Timing
- Decode is combinational from InstrD; all E outputs appear 1 cycle after InstrD is presented.
- Rs1D/Rs2D: 0-cycle combinational.
- **Reset** (reset=0 at an edge):
  - Every E output becomes 0.
  - All 32 registers are cleared to 0.
  - Reset overrides a simultaneous register write and a simultaneous FlushE.
  - Reset asserted mid-stream discards the instruction in flight; the first valid E output appears 1 cycle after reset deasserts.
- **FlushE=1 at an edge:** every E output becomes 0, giving a bubble with RegWriteE=MemWriteE=BranchE=JumpE=0. The register-file write in that same cycle still occurs.
- **Same-cycle write and read of the same register:** the bypass makes the new value visible in RD1E/RD2E at the next edge.
- A writeback to x0 has no effect, including through the bypass.
- No stall input. The upstream IF/ID register holds InstrD when stalling; the stage re-decodes the held value.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with InstrD=0x002081B3 → all E outputs 0. Then write x1 via writeback and check that a read of x2 gives RD2E=0.
- **R-type and bypass:** write x1=5, x2=7 via writeback. Present InstrD=0x002081B3 (add x3,x1,x2) → RD1E=5, RD2E=7, RdE=3, ALUControlE=000, RegWriteE=1. Then present 0x402081B3 → ALUControlE=001.
- **Immediate formats:**
  - 0x0020A223 (sw x2,4(x1)) → ImmExtE=0x00000004, MemWriteE=1, RegWriteE=0, ALUSrcE=1.
  - 0xFE000EE3 (beq x0,x0,-4) → ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
  - 0x008000EF (jal x1,8) → ImmExtE=8, JumpE=1, ResultSrcE=10.
- **Bypass and x0:**
  - RegWriteW=1, RdW=1, ResultW=0x12345678 in the same cycle as InstrD=0x002081B3 → RD1E=0x12345678.
  - RdW=0, ResultW=0xFFFFFFFF, then a read of x0 → 0.
- **Flush:** InstrD=0x00500093 (addi x1,x0,5) with FlushE=1 → all E outputs 0. Next cycle with FlushE=0 → ImmExtE=5, RegWriteE=1, ALUSrcE=1, RdE=1.
- **Unknown opcode:** InstrD=0x0000007F → RegWriteE, MemWriteE, BranchE and JumpE are all 0.
